tl_ul_master_bridge: RTL and testbench
======================================

Name: tl_ul_master_bridge

Overview:
- Sits directly downstream of the CPU request front-end.
- Accepts single-cycle cpu_wr/cpu_rd request pulses, plus byte enables, word address and write data.
- Issues one TileLink-UL A-channel message per request (PutFullData / PutPartialData / Get) and consumes the matching D-channel response.
- Returns read data to the front-end and drives trans_over, which gates the next request.

Parameters:
- ADDR_W, 6, a_address width; a_address = {cpu_addr, 2'b00}, zero-extended or truncated to ADDR_W.
- SOURCE_W, 1, width of a_source/d_source.
- SOURCE_ID, 0, constant source ID driven on a_source and expected on d_source.
- TIMEOUT, 255, maximum cycles spent in RSP before abort; must be ≥1; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- cpu_wr  in  1  write request pulse (valid only while trans_over=1)
- cpu_rd  in  1  read request pulse
- cpu_byte  in  4  byte enables
- cpu_addr  in  4  word address
- cpu_wdata  in  32  write data
- cpu_rdata_v  out  1  read data valid, 1-cycle pulse
- cpu_rdata  out  32  read data, held until the next read completes
- trans_over  out  1  bridge idle, able to accept a request
- a_valid  out  1
- a_ready  in  1
- a_opcode  out  3
- a_param  out  3
- a_size  out  2
- a_source  out  SOURCE_W
- a_address  out  ADDR_W
- a_mask  out  4
- a_data  out  32
- d_valid  in  1
- d_ready  out  1
- d_opcode  in  3
- d_source  in  SOURCE_W
- d_data  in  32
- d_error  in  1
- err  out  1  error pulse: d_error, bad opcode/source, stray response, or timeout
- timeout  out  1  timeout pulse

Behaviour:
- Reset (rst_n asynchronous, active-low; clock clk): state=IDLE; trans_over=1; a_valid=0; d_ready=1; cpu_rdata_v=0; cpu_rdata=0; err=0; timeout=0; all A payload registers 0.
- trans_over = (state==IDLE), decoded from the state register only; no combinational path from any input.
- FSM IDLE:
  - On cpu_wr or cpu_rd, capture the request into A registers and go to REQ.
  - a_valid is high on the next cycle, i.e. 1 cycle after the request.
  - If cpu_wr and cpu_rd are asserted in the same cycle, the write wins and the read is discarded.
- Opcode encoding:
  - Write with cpu_byte==4'hF: a_opcode=0 (PutFullData).
  - Write with any other cpu_byte, including 0: a_opcode=1 (PutPartialData).
  - Read: a_opcode=4 (Get), a_mask=4'hF, a_data=0.
  - Always: a_size=2, a_param=0, a_source=SOURCE_ID.
- FSM REQ:
  - a_valid held high and the A payload held stable until a_ready.
  - On the handshake edge, go to RSP and clear the timeout counter.
  - Requests arriving in REQ are ignored.
- FSM RSP:
  - d_ready=1; the counter increments each cycle without d_valid.
  - d_valid handshake with d_source==SOURCE_ID and the expected opcode (AccessAck=0 for a write, AccessAckData=1 for a read): go to IDLE.
  - For a read, cpu_rdata<=d_data and cpu_rdata_v pulses on the following cycle, the same cycle trans_over returns high.
  - d_error=1 still completes the transaction and pulses err. A read with d_error still updates cpu_rdata and pulses cpu_rdata_v.
  - Wrong opcode or source: pulse err, return to IDLE, no cpu_rdata_v.
  - Counter reaches TIMEOUT: pulse timeout and err, return to IDLE.
- FSM IDLE d_ready: d_ready=1 so a late or stray response is drained; each such beat pulses err and is otherwise ignored.
- Latency:
  - Request pulse at edge N → a_valid high in cycle N+1.
  - Zero-wait slave: a_ready in cycle N+1 → RSP in cycle N+2.
  - D handshake at edge M → trans_over=1 and cpu_rdata_v=1 in cycle M+1.
- Reset mid-transaction returns to IDLE immediately. No replay; any in-flight response is drained as stray.

Decomposition:
- Shared package tl_ul_pkg holds:
  - opcode constants: PUT_FULL=0, PUT_PARTIAL=1, GET=4, ACK=0, ACK_DATA=1;
  - the state enum IDLE/REQ/RSP;
  - A/D field widths.
- One natural sub-module: tl_ul_req_builder, combinational. It maps {wr, byte, addr, wdata} to {opcode, mask, address, data, size}.
- The FSM, timeout counter and response checker stay in the top module.

Test Plan:
- Full write: cpu_wr, byte=F, addr=3, wdata=DEADBEEF, a_ready tied 1, AccessAck after 2 cycles → a_opcode=0, a_address=0x0C, a_mask=F; trans_over low 4 cycles; no rdata_v.
- Partial write plus backpressure: byte=4'b0101, a_ready low 5 cycles → a_opcode=1, mask=5; a_valid held and payload stable through the stall.
- Read: cpu_rd, addr=7, response AccessAckData data=12345678 → a_opcode=4, mask=F; cpu_rdata_v one-cycle pulse with cpu_rdata=12345678 in the same cycle trans_over rises.
- Simultaneous wr+rd: → exactly one PutFullData is issued and no Get; a request pulse while busy produces no A message.
- Errors:
  - d_error=1 on a read → err pulse and rdata_v pulse.
  - d_source mismatch → err, no rdata_v.
  - No response with TIMEOUT=8 → timeout and err pulse 8 cycles after entering RSP, back to IDLE.
  - A later stray D beat → err pulse.
- Reset asserted while in REQ → all outputs return to reset values asynchronously; the next request proceeds normally.

Source files
------------

// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL constants, field widths and FSM state for the CPU master bridge.
package tl_ul_pkg;

  localparam int OP_W    = 3;
  localparam int PARAM_W = 3;
  localparam int SIZE_W  = 2;
  localparam int MASK_W  = 4;
  localparam int DATA_W  = 32;

  localparam logic [OP_W-1:0] PUT_FULL    = 3'd0;
  localparam logic [OP_W-1:0] PUT_PARTIAL = 3'd1;
  localparam logic [OP_W-1:0] GET         = 3'd4;
  localparam logic [OP_W-1:0] ACK         = 3'd0;
  localparam logic [OP_W-1:0] ACK_DATA    = 3'd1;

  // log2 of the byte count: every access is one 32-bit word
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [SIZE_W-1:0] size;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
  } a_pld_t;

endpackage

// File: rtl/tl_ul_req_builder.sv
// Maps a CPU request onto the A-channel payload; purely combinational.
module tl_ul_req_builder
  import tl_ul_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              wr,
  input  logic [MASK_W-1:0] byte_en,
  input  logic [3:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output a_pld_t            pld,
  output logic [ADDR_W-1:0] address
);

  // word address to byte address, zero-extended or truncated to the bus width
  assign address = ADDR_W'({addr, 2'b00});

  always_comb begin
    pld.size = SIZE_WORD;
    if (wr) begin
      pld.opcode = (byte_en == 4'hF) ? PUT_FULL : PUT_PARTIAL;
      pld.mask   = byte_en;
      pld.data   = wdata;
    end else begin
      pld.opcode = GET;
      pld.mask   = 4'hF;
      pld.data   = '0;
    end
  end

endmodule

// File: rtl/tl_ul_master_bridge.sv
// CPU pulse interface to TileLink-UL master: one A message per request, D response
// checked against the expected opcode/source, with a bounded wait in RSP.
module tl_ul_master_bridge
  import tl_ul_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int SOURCE_W  = 1,
  parameter int SOURCE_ID = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_wr,
  input  logic                cpu_rd,
  input  logic [MASK_W-1:0]   cpu_byte,
  input  logic [3:0]          cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_rdata_v,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                trans_over,
  output logic                a_valid,
  input  logic                a_ready,
  output logic [OP_W-1:0]     a_opcode,
  output logic [PARAM_W-1:0]  a_param,
  output logic [SIZE_W-1:0]   a_size,
  output logic [SOURCE_W-1:0] a_source,
  output logic [ADDR_W-1:0]   a_address,
  output logic [MASK_W-1:0]   a_mask,
  output logic [DATA_W-1:0]   a_data,
  input  logic                d_valid,
  output logic                d_ready,
  input  logic [OP_W-1:0]     d_opcode,
  input  logic [SOURCE_W-1:0] d_source,
  input  logic [DATA_W-1:0]   d_data,
  input  logic                d_error,
  output logic                err,
  output logic                timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [SOURCE_W-1:0] SRC      = SOURCE_W'(SOURCE_ID);

  state_t            state, state_n;
  a_pld_t            pld_d, pld_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              wr_q;
  logic [CNT_W-1:0]  cnt;

  logic load, clr_cnt, inc_cnt, err_n, to_n, rdv_n;

  tl_ul_req_builder #(.ADDR_W(ADDR_W)) u_builder (
    .wr      (cpu_wr),
    .byte_en (cpu_byte),
    .addr    (cpu_addr),
    .wdata   (cpu_wdata),
    .pld     (pld_d),
    .address (addr_d)
  );

  assign trans_over = (state == IDLE);
  assign a_valid    = (state == REQ);
  // Always ready: responses are consumed in RSP and drained as stray elsewhere
  assign d_ready    = 1'b1;
  assign a_opcode   = pld_q.opcode;
  assign a_size     = pld_q.size;
  assign a_mask     = pld_q.mask;
  assign a_data     = pld_q.data;
  assign a_address  = addr_q;
  assign a_param    = '0;
  assign a_source   = SRC;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;

  always_comb begin
    state_n = state;
    load    = 1'b0;
    clr_cnt = 1'b0;
    inc_cnt = 1'b0;
    err_n   = 1'b0;
    to_n    = 1'b0;
    rdv_n   = 1'b0;
    case (state)
      IDLE: begin
        err_n = d_valid;
        if (cpu_wr || cpu_rd) begin
          load    = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        err_n = d_valid;
        if (a_ready) begin
          clr_cnt = 1'b1;
          state_n = RSP;
        end
      end
      RSP: begin
        if (d_valid) begin
          state_n = IDLE;
          if (d_source == SRC && d_opcode == (wr_q ? ACK : ACK_DATA)) begin
            err_n = d_error;
            rdv_n = !wr_q;
          end else begin
            err_n = 1'b1;
          end
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE;
          to_n    = 1'b1;
          err_n   = 1'b1;
        end else begin
          inc_cnt = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // payload is only loaded in IDLE, so it stays stable through any A stall
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pld_q  <= '0;
      addr_q <= '0;
      wr_q   <= 1'b0;
    end else if (load) begin
      pld_q  <= pld_d;
      addr_q <= addr_d;
      wr_q   <= cpu_wr;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       cnt <= '0;
    else if (clr_cnt) cnt <= '0;
    else if (inc_cnt) cnt <= cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cpu_rdata_v <= 1'b0;
      cpu_rdata   <= '0;
      err         <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      cpu_rdata_v <= rdv_n;
      err         <= err_n;
      timeout     <= to_n;
      if (rdv_n) cpu_rdata <= d_data;
    end

endmodule

// File: tb/tb_tl_ul_master_bridge.sv
// Directed bench for tl_ul_master_bridge: write/read/backpressure/error/timeout/reset vectors.
module tb_tl_ul_master_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_wr, cpu_rd;
  logic [3:0]  cpu_byte, cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_rdata_v;
  logic [31:0] cpu_rdata;
  logic        trans_over;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param;
  logic [1:0]  a_size;
  logic [0:0]  a_source;
  logic [5:0]  a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode;
  logic [0:0]  d_source;
  logic [31:0] d_data;
  logic        d_error;
  logic        err, timeout;

  int n_chk = 0, n_err = 0;
  int busy_cnt, rdv_cnt, err_cnt, a_cnt;
  logic [2:0] last_op;

  always #5 clk = ~clk;

  tl_ul_master_bridge #(.ADDR_W(6), .SOURCE_W(1), .SOURCE_ID(0), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_byte(cpu_byte), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata_v(cpu_rdata_v), .cpu_rdata(cpu_rdata),
    .trans_over(trans_over),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_source(d_source),
    .d_data(d_data), .d_error(d_error),
    .err(err), .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    busy_cnt = 0; rdv_cnt = 0; err_cnt = 0; a_cnt = 0;
  endtask

  // one cycle: note an A handshake about to happen, then sample at the next falling edge
  task automatic step();
    if (a_valid && a_ready) begin
      a_cnt++;
      last_op = a_opcode;
    end
    @(negedge clk);
    if (!trans_over) busy_cnt++;
    if (cpu_rdata_v) rdv_cnt++;
    if (err)         err_cnt++;
  endtask

  task automatic req(input logic wr, input logic rd, input logic [3:0] be,
                     input logic [3:0] ad, input logic [31:0] wd);
    cpu_wr = wr; cpu_rd = rd; cpu_byte = be; cpu_addr = ad; cpu_wdata = wd;
    step();
    cpu_wr = 1'b0; cpu_rd = 1'b0;
  endtask

  task automatic rsp(input logic [2:0] op, input logic src, input logic [31:0] dat,
                     input logic derr);
    d_valid = 1'b1; d_opcode = op; d_source = src; d_data = dat; d_error = derr;
    step();
    d_valid = 1'b0; d_error = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cpu_wr = 0; cpu_rd = 0; cpu_byte = 0; cpu_addr = 0; cpu_wdata = 0;
    a_ready = 1'b1; d_valid = 0; d_opcode = 0; d_source = 0; d_data = 0; d_error = 0;
    last_op = 3'd7;
    clr_stats();
    step(); step();
    chk("rst_trans_over", trans_over, 1);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_d_ready", d_ready, 1);
    chk("rst_rdata_v", cpu_rdata_v, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_a_payload", {a_opcode, a_size, a_mask, a_address}, 0);
    chk("rst_a_data", a_data, 0);
    rst_n = 1'b1;
    step();

    // full write, zero-wait slave, AccessAck two cycles into RSP
    clr_stats();
    req(1, 0, 4'hF, 4'd3, 32'hDEADBEEF);
    chk("wr_a_valid", a_valid, 1);
    chk("wr_opcode", a_opcode, 0);
    chk("wr_address", a_address, 6'h0C);
    chk("wr_mask", a_mask, 4'hF);
    chk("wr_data", a_data, 32'hDEADBEEF);
    chk("wr_size_param_src", {a_size, a_param, a_source}, {2'd2, 3'd0, 1'b0});
    step(); step(); step();
    rsp(3'd0, 1'b0, 32'h0, 1'b0);
    chk("wr_done", trans_over, 1);
    chk("wr_busy_cycles", busy_cnt, 4);
    chk("wr_no_rdv", rdv_cnt, 0);
    chk("wr_no_err", err_cnt, 0);

    // partial write held off by a_ready for five cycles
    clr_stats();
    a_ready = 1'b0;
    req(1, 0, 4'b0101, 4'd2, 32'hA5A55A5A);
    chk("pw_opcode", a_opcode, 1);
    chk("pw_mask", a_mask, 4'h5);
    chk("pw_address", a_address, 6'h08);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pw_stall_valid", a_valid, 1);
      chk("pw_stall_payload", {a_opcode, a_mask, a_address}, {3'd1, 4'h5, 6'h08});
      chk("pw_stall_data", a_data, 32'hA5A55A5A);
    end
    a_ready = 1'b1;
    step();
    chk("pw_in_rsp", a_valid, 0);
    rsp(3'd0, 1'b0, 32'h0, 1'b0);
    chk("pw_done", trans_over, 1);
    chk("pw_one_msg", a_cnt, 1);

    // read with AccessAckData
    clr_stats();
    req(0, 1, 4'h0, 4'd7, 32'hFFFFFFFF);
    chk("rd_opcode", a_opcode, 4);
    chk("rd_mask", a_mask, 4'hF);
    chk("rd_data_zero", a_data, 0);
    chk("rd_address", a_address, 6'h1C);
    step();
    rsp(3'd1, 1'b0, 32'h12345678, 1'b0);
    chk("rd_rdv", cpu_rdata_v, 1);
    chk("rd_rdata", cpu_rdata, 32'h12345678);
    chk("rd_trans_over", trans_over, 1);
    step();
    chk("rd_rdv_pulse", cpu_rdata_v, 0);
    chk("rd_rdata_hold", cpu_rdata, 32'h12345678);

    // simultaneous wr+rd, then a read pulse while busy
    clr_stats();
    req(1, 1, 4'hF, 4'd1, 32'h11112222);
    chk("wrrd_opcode", a_opcode, 0);
    chk("wrrd_address", a_address, 6'h04);
    step();
    req(0, 1, 4'hF, 4'd5, 32'h0);
    step();
    rsp(3'd0, 1'b0, 32'h0, 1'b0);
    step();
    chk("wrrd_no_replay", a_valid, 0);
    chk("wrrd_one_msg", a_cnt, 1);
    chk("wrrd_put_full", last_op, 0);
    chk("wrrd_no_rdv", rdv_cnt, 0);

    // read completing with d_error
    clr_stats();
    req(0, 1, 4'hF, 4'd2, 32'h0);
    step();
    rsp(3'd1, 1'b0, 32'hCAFEF00D, 1'b1);
    chk("derr_err", err, 1);
    chk("derr_rdv", cpu_rdata_v, 1);
    chk("derr_rdata", cpu_rdata, 32'hCAFEF00D);
    step();
    chk("derr_err_pulse", err, 0);

    // read answered with the wrong source
    clr_stats();
    req(0, 1, 4'hF, 4'd4, 32'h0);
    step();
    rsp(3'd1, 1'b1, 32'h0BADBAD0, 1'b0);
    chk("src_err", err, 1);
    chk("src_no_rdv", cpu_rdata_v, 0);
    chk("src_rdata_kept", cpu_rdata, 32'hCAFEF00D);
    chk("src_idle", trans_over, 1);

    // write with byte enables 0 that never gets a response
    clr_stats();
    req(1, 0, 4'h0, 4'd1, 32'h0);
    chk("to_opcode_partial", a_opcode, 1);
    chk("to_mask_zero", a_mask, 0);
    step();
    for (int i = 0; i < 7; i++) step();
    chk("to_not_yet", timeout, 0);
    chk("to_still_busy", trans_over, 0);
    step();
    chk("to_timeout", timeout, 1);
    chk("to_err", err, 1);
    chk("to_idle", trans_over, 1);
    step();
    chk("to_pulse", timeout, 0);

    // stray D beat while idle
    clr_stats();
    rsp(3'd0, 1'b0, 32'h0, 1'b0);
    chk("stray_err", err, 1);
    chk("stray_idle", trans_over, 1);
    chk("stray_no_rdv", cpu_rdata_v, 0);

    // asynchronous reset while stalled in REQ
    a_ready = 1'b0;
    req(1, 0, 4'hF, 4'd6, 32'h55AA55AA);
    chk("rreq_valid", a_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rreq_a_valid", a_valid, 0);
    chk("rreq_trans_over", trans_over, 1);
    chk("rreq_payload", {a_opcode, a_mask, a_address}, 0);
    chk("rreq_data", a_data, 0);
    chk("rreq_rdata", cpu_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a_ready = 1'b1;
    req(0, 1, 4'hF, 4'd9, 32'h0);
    chk("rreq_next_opcode", a_opcode, 4);
    chk("rreq_next_addr", a_address, 6'h24);
    step();
    rsp(3'd1, 1'b0, 32'h0F0F0F0F, 1'b0);
    chk("rreq_next_rdv", cpu_rdata_v, 1);
    chk("rreq_next_rdata", cpu_rdata, 32'h0F0F0F0F);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
